// File: rtl/jtag_dmi_dr.sv
// JTAG data registers for a RISC-V debug transport module: IDCODE, DTMCS,
// DMI and BYPASS scan chains, plus the DMI request/response sequencer.
//
// Handshakes: a DMI request transfers on a rising tck_i edge where
// dmi_req_valid_o and dmi_req_ready_i are both high; addr/data/op hold steady
// while valid is high. A response transfers on an edge where dmi_resp_valid_i
// and dmi_resp_ready_o are both high. Valid never waits on ready.
module jtag_dmi_dr #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int unsigned ABITS        = 7
) (
  input  logic             tck_i,
  input  logic             trst_ni,
  input  logic [4:0]       ir_i,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic             td_i,
  output logic             dr_tdo_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_op_i,
  output logic [1:0]       dbg_state
);

  localparam int DW = ABITS + 34;
  localparam logic [5:0] ABITS6 = 6'(ABITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      idcode_sr;
  logic [31:0]      dtmcs_sr;
  logic [DW-1:0]    dmi_sr;
  logic             bypass_sr;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      data_q;
  logic [1:0]       op_q;
  logic [1:0]       sticky_q;

  logic sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;
  logic [31:0] dtmcs_cap;
  logic [1:0]  dmi_cap_op;
  logic dmi_update, dtmcs_update, hard_reset, dmi_reset;
  logic issue, busy_access, resp_take;

  assign sel_idcode = (ir_i == 5'h01);
  assign sel_dtmcs  = (ir_i == 5'h10);
  assign sel_dmi    = (ir_i == 5'h11);
  assign sel_bypass = !(sel_idcode || sel_dtmcs || sel_dmi);

  // Busy (3) dominates; otherwise report the sticky error status.
  assign dmi_cap_op = ((state_q != ST_IDLE) || (sticky_q == 2'd3)) ? 2'b11 : sticky_q;
  assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, 3'd1, sticky_q, ABITS6, 4'd1};

  assign dmi_update   = update_dr_i && sel_dmi;
  assign dtmcs_update = update_dr_i && sel_dtmcs;
  assign hard_reset   = dtmcs_update && dtmcs_sr[17];
  assign dmi_reset    = dtmcs_update && dtmcs_sr[16];

  // A new request only starts from a clean, idle sequencer with a real op.
  assign issue = dmi_update && (state_q == ST_IDLE) && (sticky_q == 2'd0) &&
                 ((dmi_sr[1:0] == 2'd1) || (dmi_sr[1:0] == 2'd2));
  assign busy_access = sel_dmi && (capture_dr_i || update_dr_i) && (state_q != ST_IDLE);
  // Hard reset wins over a response arriving in the same cycle.
  assign resp_take = (state_q == ST_WAIT) && dmi_resp_valid_i && !hard_reset;

  // Scan chains: capture parallel value or shift right with td_i into the MSB.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_sr <= '0;
      dtmcs_sr  <= '0;
      dmi_sr    <= '0;
      bypass_sr <= 1'b0;
    end else begin
      if (sel_idcode) begin
        if (capture_dr_i)    idcode_sr <= IDCODE_VALUE;
        else if (shift_dr_i) idcode_sr <= {td_i, idcode_sr[31:1]};
      end
      if (sel_dtmcs) begin
        if (capture_dr_i)    dtmcs_sr <= dtmcs_cap;
        else if (shift_dr_i) dtmcs_sr <= {td_i, dtmcs_sr[31:1]};
      end
      if (sel_dmi) begin
        if (capture_dr_i)    dmi_sr <= {addr_q, data_q, dmi_cap_op};
        else if (shift_dr_i) dmi_sr <= {td_i, dmi_sr[DW-1:1]};
      end
      if (sel_bypass) begin
        if (capture_dr_i)    bypass_sr <= 1'b0;
        else if (shift_dr_i) bypass_sr <= td_i;
      end
    end
  end

  // Serial output: LSB of the selected chain.
  always_comb begin
    dr_tdo_o = bypass_sr;
    if (sel_idcode)     dr_tdo_o = idcode_sr[0];
    else if (sel_dtmcs) dr_tdo_o = dtmcs_sr[0];
    else if (sel_dmi)   dr_tdo_o = dmi_sr[0];
  end

  // Sequencer state register.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Sequencer next state; hard reset overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_REQ;
      ST_REQ:  if (dmi_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (dmi_resp_valid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (hard_reset) state_d = ST_IDLE;
  end

  // Sticky status: cleared by dmireset/dmihardreset, set busy on overlap,
  // set failed on an error response.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      sticky_q <= 2'd0;
    end else if (hard_reset || dmi_reset) begin
      sticky_q <= 2'd0;
    end else if (busy_access) begin
      sticky_q <= 2'd3;
    end else if (resp_take && (dmi_resp_op_i != 2'd0)) begin
      sticky_q <= 2'd2;
    end
  end

  // Request fields latch at issue; data is overwritten by the response.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      op_q   <= 2'd0;
    end else if (issue) begin
      addr_q <= dmi_sr[DW-1:34];
      data_q <= dmi_sr[33:2];
      op_q   <= dmi_sr[1:0];
    end else if (resp_take) begin
      data_q <= dmi_resp_data_i;
    end
  end

  assign dmi_req_valid_o  = (state_q == ST_REQ);
  assign dmi_resp_ready_o = (state_q == ST_WAIT);
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_req_op_o     = op_q;
  assign dbg_state        = state_q;

endmodule
